dmem_ctrl: RTL

Backing-memory responder on the far side of the data cache: serves line refills and line write-backs issued by the cache on a miss or dirty eviction. Accepts one request at a time over a valid/ready request channel, streams write data in or read data out as `LINE_WORDS` word beats, and models a fixed access latency. It is the memory end of the interface whose requester is the cache feeding the memory pipeline stage; while it is busy, the cache holds its stall asserted.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the backing-memory responder: default geometry,
// FSM state encoding and the line word-index helper.
package mem_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned LATENCY_DEF    = 3;
    localparam int unsigned MEM_WORDS_DEF  = 1024;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_DATA,
        ST_WR_WAIT
    } state_e;

    // Byte address -> line-aligned word index, wrapped to the array depth.
    function automatic logic [ADDR_W-1:0] line_word_idx(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       line_words,
        input int unsigned       mem_words
    );
        logic [ADDR_W-1:0] word;
        word = addr >> 2;
        word = word & ~(ADDR_W'(line_words) - ADDR_W'(1));
        word = word & (ADDR_W'(mem_words) - ADDR_W'(1));
        return word;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Cache-to-memory line transfer channel: request, write beats, read beats.
interface dmem_ctrl_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output req_valid, req_is_store, req_addr, wr_valid, wr_data,
        input  req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  req_valid, req_is_store, req_addr, wr_valid, wr_data,
        output req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read data.
module dmem_array
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Storage itself is never reset; contents survive a controller reset.
    always_ff @(posedge clock) begin
        if (en && we) mem[addr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)          rdata <= '0;
        else if (en && !we)  rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Line refill / write-back responder behind the data cache, with a fixed
// access latency before read data or write completion is returned.
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned LATENCY    = LATENCY_DEF,
    parameter int unsigned MEM_WORDS  = MEM_WORDS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    dmem_ctrl_if.slave  bus
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned BW = $clog2(LINE_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(LATENCY - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            req_ready_q, req_ready_d;
    logic            wr_ready_q, wr_ready_d;
    logic            wr_done_q, wr_done_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // Next-state and next-output decode; array access is issued one cycle
    // ahead of each read beat so the registered read port lines up.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        wr_done_d  = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = base_q + AW'(beat_q);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    base_d = AW'(line_word_idx(bus.req_addr, LINE_WORDS, MEM_WORDS));
                    beat_d = '0;
                    wait_d = WAIT_INIT;
                    if (bus.req_is_store) state_d = ST_WR_DATA;
                    else                  state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == '0) begin
                    mem_en     = 1'b1;
                    beat_d     = beat_q + BW'(1);
                    rd_valid_d = 1'b1;
                    state_d    = ST_RD_BURST;
                end else begin
                    wait_d = wait_q - CW'(1);
                end
            end
            ST_RD_BURST: begin
                if (rd_last_q) begin
                    beat_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    mem_en     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (beat_q == LAST_BEAT);
                    beat_d     = beat_q + BW'(1);
                end
            end
            ST_WR_DATA: begin
                if (bus.wr_valid) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        wait_d  = WAIT_INIT;
                        state_d = ST_WR_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (wr_done_q) begin
                    state_d = ST_IDLE;
                end else if (wait_q == '0) begin
                    wr_done_d = 1'b1;
                end else begin
                    wait_d = wait_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        wr_ready_d  = (state_d == ST_WR_DATA);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            wr_done_q   <= wr_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus.wr_data),
        .rdata (mem_rdata)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = mem_rdata;

endmodule
